dmem_arbiter: RTL and testbench

Arbitrates the single data port of the unified synchronous-read memory between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/loader engine. The memory supports only word-wide writes, so this block performs read-modify-write for byte and halfword stores. It sits between the requesters and the memory's addr_d/rdata/wen/wdata pins.

---
 rtl/dmem_arbiter_if.sv | 38 +++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Two-requester data-memory bus: port 0/1 request+response channels and the
// memory-side pins, bundled for the arbiter (slave) and requesters (master).
interface dmem_arbiter_if #(
  parameter int WLEN = 32
);
  logic            req0_valid, req0_ready, req0_wen;
  logic [WLEN-1:0] req0_addr, req0_wdata;
  logic [3:0]      req0_wstrb;
  logic            rsp0_valid;
  logic [WLEN-1:0] rsp0_rdata;

  logic            req1_valid, req1_ready, req1_wen;
  logic [WLEN-1:0] req1_addr, req1_wdata;
  logic [3:0]      req1_wstrb;
  logic            rsp1_valid;
  logic [WLEN-1:0] rsp1_rdata;

  logic [WLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic            mem_wen;

  modport slave (
    input  req0_valid, req0_addr, req0_wen, req0_wstrb, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_addr, req1_wen, req1_wstrb, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_addr, mem_wen, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_addr, req0_wen, req0_wstrb, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_addr, req1_wen, req1_wstrb, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_addr, mem_wen, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single data-memory port; turns byte/halfword
// stores into an atomic read-modify-write against the word-only memory.
module dmem_arbiter #(
  parameter int WLEN      = 32,
  parameter bit PRIO_INIT = 1'b1
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RESP, MERGE, WDONE} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [WLEN-1:0] addr_q, addr_d;
  logic [WLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;

  logic [1:0]           req_valid, req_wen, vld, ready, rsp_valid;
  logic [1:0][WLEN-1:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0]      req_wstrb;
  logic                 gnt;
  logic [WLEN-1:0]      merged, mem_addr, mem_wdata;
  logic                 mem_wen;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_wen   = {bus.req1_wen,   bus.req0_wen};
  assign req_addr  = {bus.req1_addr,  bus.req0_addr};
  assign req_wdata = {bus.req1_wdata, bus.req0_wdata};
  assign req_wstrb = {bus.req1_wstrb, bus.req0_wstrb};

  // Requests are invisible while reset is held so nothing is granted.
  assign vld = rst ? 2'b00 : req_valid;

  always_comb begin
    gnt = vld[1];
    if (vld == 2'b11) gnt = ~last_grant_q;
  end

  always_comb begin
    merged = bus.mem_rdata;
    for (int i = 0; i < 4; i++)
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    ready        = 2'b00;
    rsp_valid    = 2'b00;
    rsp_rdata    = '0;
    mem_addr     = addr_q;
    mem_wen      = 1'b0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        if (|vld) begin
          ready[gnt]   = 1'b1;
          mem_addr     = req_addr[gnt];
          last_grant_d = gnt;
          owner_d      = gnt;
          addr_d       = req_addr[gnt];
          wdata_d      = req_wdata[gnt];
          wstrb_d      = req_wstrb[gnt];
          if (!req_wen[gnt]) begin
            state_d = RESP;
          end else if (req_wstrb[gnt] == 4'hF) begin
            mem_wen   = 1'b1;
            mem_wdata = req_wdata[gnt];
            state_d   = WDONE;
          end else if (req_wstrb[gnt] == 4'h0) begin
            state_d = WDONE;
          end else begin
            state_d = MERGE;
          end
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_rdata[owner_q] = bus.mem_rdata;
        state_d            = IDLE;
      end
      // Read phase happened in the accept cycle; mem_rdata now holds the old word.
      MERGE: begin
        mem_wen   = 1'b1;
        mem_wdata = merged;
        state_d   = WDONE;
      end
      WDONE: begin
        rsp_valid[owner_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PRIO_INIT;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_rdata = rsp_rdata[0];
  assign bus.rsp1_rdata = rsp_rdata[1];
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wen    = mem_wen;
  assign bus.mem_wdata  = mem_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: requester tasks push expected responses,
// a negedge monitor pops and checks them against what the DUT returns.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.WLEN(32)) bus();
  dmem_arbiter #(.WLEN(32), .PRIO_INIT(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wen_total = 0;
  logic [31:0] last_wdata, last_waddr;

  typedef struct {int port; logic [31:0] rdata; int cyc;} exp_t;
  exp_t sb[$];
  int   grants[$];
  int   acc_cyc[2];
  exp_t mon_e;

  // Word memory model; never-written words read as A5A5_00<index>.
  logic [31:0] mem [256];
  bit          written [256];

  function automatic logic [31:0] rd_word(input logic [7:0] i);
    return written[i] ? mem[i] : (32'hA5A5_0000 | {24'h0, i});
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wen) begin
      mem[bus.mem_addr[9:2]]     <= bus.mem_wdata;
      written[bus.mem_addr[9:2]] <= 1'b1;
      wen_total  <= wen_total + 1;
      last_wdata <= bus.mem_wdata;
      last_waddr <= bus.mem_addr;
    end
    bus.mem_rdata <= rd_word(bus.mem_addr[9:2]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rsp both valid", {31'b0, bus.rsp0_valid & bus.rsp1_valid}, 0);
    if (!bus.rsp0_valid) chk("rsp0_rdata idle", bus.rsp0_rdata, 0);
    if (!bus.rsp1_valid) chk("rsp1_rdata idle", bus.rsp1_rdata, 0);
    if (bus.rsp0_valid || bus.rsp1_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected rsp: rsp0_valid %b rsp1_valid %b at cycle %0d",
                 bus.rsp0_valid, bus.rsp1_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp port", bus.rsp1_valid ? 1 : 0, mon_e.port);
        chk("rsp rdata", bus.rsp1_valid ? bus.rsp1_rdata : bus.rsp0_rdata, mon_e.rdata);
        chk("rsp cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic drive(input int p, input logic v, input logic [31:0] a, input logic w,
                       input logic [3:0] s, input logic [31:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_addr = a; bus.req0_wen = w;
      bus.req0_wstrb = s; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_addr = a; bus.req1_wen = w;
      bus.req1_wstrb = s; bus.req1_wdata = d;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  // Called in the low clock phase; returns at the negedge after acceptance
  // with valid still asserted (caller drops it).
  task automatic issue(input int p, input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] er, input int lat);
    exp_t e;
    logic rdy;
    int   n;
    drive(p, 1'b1, a, w, s, d);
    n = 0;
    forever begin
      #1;
      rdy = (p == 0) ? bus.req0_ready : bus.req1_ready;
      if (rdy) break;
      n++;
      if (n > 40) begin
        chk($sformatf("ready%0d timeout", p), {31'b0, rdy}, 1);
        drop(p);
        return;
      end
      @(negedge clk);
    end
    e.port = p; e.rdata = er; e.cyc = cyc + lat;
    sb.push_back(e);
    grants.push_back(p);
    acc_cyc[p] = cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 1'b0;
    drive(0, 1'b0, 0, 1'b0, 4'h0, 0);
    drive(1, 1'b0, 0, 1'b0, 4'h0, 0);
    #1 rst = 1'b1;
    // Both ports hold loads straight out of reset.
    drive(0, 1'b1, 32'h40, 1'b0, 4'h0, 0);
    drive(1, 1'b1, 32'h44, 1'b0, 4'h0, 0);
    #2;
    chk("reset req0_ready", {31'b0, bus.req0_ready}, 0);
    chk("reset req1_ready", {31'b0, bus.req1_ready}, 0);
    chk("reset mem_wen", {31'b0, bus.mem_wen}, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_wdata", bus.mem_wdata, 0);
    chk("reset rsp0_valid", {31'b0, bus.rsp0_valid}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    fork
      begin
        issue(0, 32'h40, 1'b0, 4'h0, 0, 32'hA5A5_0010, 1);
        issue(0, 32'h48, 1'b0, 4'h0, 0, 32'hA5A5_0012, 1);
        drop(0);
      end
      begin
        issue(1, 32'h44, 1'b0, 4'h0, 0, 32'hA5A5_0011, 1);
        issue(1, 32'h4C, 1'b0, 4'h0, 0, 32'hA5A5_0013, 1);
        drop(1);
      end
    join
    chk("rr grant count", grants.size(), 4);
    chk("rr grant 0", grants[0], 0);
    chk("rr grant 1", grants[1], 1);
    chk("rr grant 2", grants[2], 0);
    chk("rr grant 3", grants[3], 1);
    @(negedge clk);

    // Full-word store then load back.
    w0 = wen_total;
    issue(0, 32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 1); drop(0);
    @(negedge clk);
    chk("full store wen count", wen_total - w0, 1);
    chk("full store waddr", last_waddr, 32'h100);
    chk("full store wdata", last_wdata, 32'hDEAD_BEEF);
    issue(0, 32'h100, 1'b0, 4'h0, 0, 32'hDEAD_BEEF, 1); drop(0);
    @(negedge clk);

    // Byte store through read-modify-write.
    issue(1, 32'h200, 1'b1, 4'hF, 32'h1122_3344, 0, 1); drop(1);
    @(negedge clk);
    w0 = wen_total;
    issue(1, 32'h200, 1'b1, 4'b0010, 32'h0000_AA00, 0, 2); drop(1);
    repeat (2) @(negedge clk);
    chk("byte store wen count", wen_total - w0, 1);
    chk("byte store waddr", last_waddr, 32'h200);
    chk("byte store merged", last_wdata, 32'h1122_AA44);
    issue(1, 32'h200, 1'b0, 4'h0, 0, 32'h1122_AA44, 1); drop(1);
    @(negedge clk);

    // Halfword RMW from port 0 while port 1 waits with a load.
    fork
      begin issue(0, 32'h200, 1'b1, 4'b1100, 32'hBEEF_0000, 0, 2); drop(0); end
      begin issue(1, 32'h200, 1'b0, 4'h0, 0, 32'hBEEF_AA44, 1); drop(1); end
    join
    chk("rmw holds off port1", acc_cyc[1] - acc_cyc[0], 3);
    @(negedge clk);

    // Zero-strobe store writes nothing.
    w0 = wen_total;
    issue(0, 32'h200, 1'b1, 4'h0, 32'hFFFF_FFFF, 0, 1); drop(0);
    repeat (2) @(negedge clk);
    chk("zero strobe wen count", wen_total - w0, 0);

    // Reset lands in the middle of MERGE.
    w0 = wen_total;
    drive(1, 1'b1, 32'h100, 1'b1, 4'b0001, 32'h0000_00CC);
    #1 chk("merge req1_ready", {31'b0, bus.req1_ready}, 1);
    @(posedge clk);
    #2 chk("merge mem_wen", {31'b0, bus.mem_wen}, 1);
    rst = 1'b1;
    #1;
    chk("async rst mem_wen", {31'b0, bus.mem_wen}, 0);
    chk("async rst rsp1_valid", {31'b0, bus.rsp1_valid}, 0);
    drop(1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset merge wen count", wen_total - w0, 0);

    // First tie after reset goes to port 0; both words intact.
    fork
      begin issue(0, 32'h100, 1'b0, 4'h0, 0, 32'hDEAD_BEEF, 1); drop(0); end
      begin issue(1, 32'h200, 1'b0, 4'h0, 0, 32'hBEEF_AA44, 1); drop(1); end
    join
    chk("post-reset grant a", grants[grants.size()-2], 0);
    chk("post-reset grant b", grants[grants.size()-1], 1);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
